dino_motion_ctrl: RTL and testbench

- Per-frame dino vertical-motion and collision engine for the T-rex game.
- Consumes the 2-bit game state and the jump button, and advances the dino jump trajectory on each frame tick.
- Checks the dino hitbox against the current obstacle and produces the `collided` event that the game-state FSM consumes. It is the producer side of the state/collided interface.

---
 rtl/game_pkg.sv | 19 +
 rtl/dino_hitbox.sv | 33 +++
 rtl/dino_motion_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dino_motion_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-state encodings and dino jump phases
package game_pkg;

    localparam int COORD_W_DEFAULT = 10;

    // Encodings shared with the game-state FSM; 2'b11 is never produced there.
    typedef logic [1:0] game_state_t;
    localparam game_state_t ST_INIT   = 2'b00;
    localparam game_state_t ST_INGAME = 2'b10;
    localparam game_state_t ST_DEAD   = 2'b01;

    typedef enum logic [1:0] {
        GROUND = 2'b00,
        RISE   = 2'b01,
        HANG   = 2'b10,
        FALL   = 2'b11
    } jump_phase_e;

endpackage

// File: rtl/dino_hitbox.sv
// rtl/dino_hitbox.sv - combinational dino/obstacle overlap comparator
module dino_hitbox #(
    parameter int COORD_W = 10,
    parameter int DINO_X  = 40,
    parameter int DINO_W  = 20,
    parameter int OBS_W   = 12,
    parameter int OBS_H   = 24
) (
    input  logic [COORD_W-1:0] obs_x_i,
    input  logic               obs_valid_i,
    input  logic [COORD_W-1:0] height_i,
    output logic               hit_o
);
    localparam logic [COORD_W:0] DINO_LEFT  = (COORD_W+1)'(DINO_X);
    localparam logic [COORD_W:0] DINO_RIGHT = (COORD_W+1)'(DINO_X + DINO_W);
    localparam logic [COORD_W:0] OBS_W_X    = (COORD_W+1)'(OBS_W);
    localparam logic [COORD_W:0] OBS_H_X    = (COORD_W+1)'(OBS_H);

    logic [COORD_W:0] obs_left;
    logic [COORD_W:0] obs_right;
    logic [COORD_W:0] height_x;

    // One extra bit so obstacles near the right screen edge cannot wrap.
    assign obs_left  = {1'b0, obs_x_i};
    assign obs_right = obs_left + OBS_W_X;
    assign height_x  = {1'b0, height_i};

    assign hit_o = obs_valid_i
                && (obs_left < DINO_RIGHT)
                && (obs_right > DINO_LEFT)
                && (height_x < OBS_H_X);

endmodule

// File: rtl/dino_motion_ctrl.sv
// rtl/dino_motion_ctrl.sv - per-frame dino jump trajectory and collision event
module dino_motion_ctrl
    import game_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEFAULT,
    parameter int GROUND_Y    = 200,
    parameter int JUMP_HEIGHT = 60,
    parameter int RISE_STEP   = 4,
    parameter int FALL_STEP   = 4,
    parameter int HANG_FRAMES = 6,
    parameter int DINO_X      = 40,
    parameter int DINO_W      = 20,
    parameter int OBS_W       = 12,
    parameter int OBS_H       = 24
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               frame_tick_i,
    input  game_state_t        state_i,
    input  logic               jump_i,
    input  logic [COORD_W-1:0] obs_x_i,
    input  logic               obs_valid_i,
    output logic [COORD_W-1:0] dino_y_o,
    output logic               airborne_o,
    output logic               collided_o
);
    localparam int HANG_W = (HANG_FRAMES > 1) ? $clog2(HANG_FRAMES) : 1;
    localparam logic [COORD_W:0]   RISE_X = (COORD_W+1)'(RISE_STEP);
    localparam logic [COORD_W:0]   FALL_X = (COORD_W+1)'(FALL_STEP);
    localparam logic [COORD_W:0]   APEX_X = (COORD_W+1)'(JUMP_HEIGHT);
    localparam logic [COORD_W-1:0] GROUND_Y_C = COORD_W'(GROUND_Y);

    jump_phase_e        phase_q, phase_d;
    logic [COORD_W-1:0] height_q, height_d;
    logic [HANG_W-1:0]  hang_q, hang_d;
    logic               jump_req_q, jump_req_d;
    logic               hit_seen_q, hit_seen_d;
    logic               upd_q, upd_d;
    logic               collided_q, collided_d;
    logic [COORD_W-1:0] dino_y_q;
    logic               airborne_q;

    logic               in_game;
    logic               in_dead;
    logic               overlap;
    logic [COORD_W:0]   rise_sum;
    logic [COORD_W:0]   height_x;

    assign in_game  = (state_i == ST_INGAME);
    assign in_dead  = (state_i == ST_DEAD);
    assign height_x = {1'b0, height_q};
    assign rise_sum = height_x + RISE_X;

    dino_hitbox #(
        .COORD_W (COORD_W),
        .DINO_X  (DINO_X),
        .DINO_W  (DINO_W),
        .OBS_W   (OBS_W),
        .OBS_H   (OBS_H)
    ) u_hitbox (
        .obs_x_i     (obs_x_i),
        .obs_valid_i (obs_valid_i),
        .height_i    (height_q),
        .hit_o       (overlap)
    );

    always_comb begin
        phase_d    = phase_q;
        height_d   = height_q;
        hang_d     = hang_q;
        jump_req_d = jump_req_q;
        hit_seen_d = hit_seen_q;
        upd_d      = 1'b0;
        collided_d = 1'b0;

        if (in_dead) begin
            jump_req_d = 1'b0;
        end else if (!in_game) begin
            // Init and the illegal 2'b11 both park the dino and rearm the hit latch.
            phase_d    = GROUND;
            height_d   = '0;
            hang_d     = '0;
            jump_req_d = 1'b0;
            hit_seen_d = 1'b0;
        end else begin
            if (frame_tick_i) begin
                jump_req_d = 1'b0;
                upd_d      = 1'b1;
                unique case (phase_q)
                    GROUND: begin
                        if (jump_req_q || jump_i) begin
                            phase_d  = RISE;
                            height_d = COORD_W'(RISE_STEP);
                        end
                    end
                    RISE: begin
                        if (rise_sum >= APEX_X) begin
                            phase_d  = HANG;
                            height_d = COORD_W'(JUMP_HEIGHT);
                            hang_d   = HANG_W'(HANG_FRAMES - 1);
                        end else begin
                            height_d = rise_sum[COORD_W-1:0];
                        end
                    end
                    HANG: begin
                        if (hang_q == '0) begin
                            phase_d = FALL;
                        end else begin
                            hang_d = hang_q - HANG_W'(1);
                        end
                    end
                    FALL: begin
                        if (height_x <= FALL_X) begin
                            phase_d  = GROUND;
                            height_d = '0;
                        end else begin
                            height_d = height_q - COORD_W'(FALL_STEP);
                        end
                    end
                    default: phase_d = GROUND;
                endcase
            end else if (jump_i && phase_q == GROUND) begin
                jump_req_d = 1'b1;
            end

            // The overlap is judged one cycle after the position moved.
            if (upd_q && overlap && !hit_seen_q) begin
                collided_d = 1'b1;
                hit_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q    <= GROUND;
            height_q   <= '0;
            hang_q     <= '0;
            jump_req_q <= 1'b0;
            hit_seen_q <= 1'b0;
            upd_q      <= 1'b0;
            collided_q <= 1'b0;
            dino_y_q   <= GROUND_Y_C;
            airborne_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            height_q   <= height_d;
            hang_q     <= hang_d;
            jump_req_q <= jump_req_d;
            hit_seen_q <= hit_seen_d;
            upd_q      <= upd_d;
            collided_q <= collided_d;
            dino_y_q   <= GROUND_Y_C - height_d;
            airborne_q <= (phase_d != GROUND);
        end
    end

    assign dino_y_o   = dino_y_q;
    assign airborne_o = airborne_q;
    assign collided_o = collided_q;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// tb/tb_dino_motion_ctrl.sv - directed self-checking bench for dino_motion_ctrl
module tb_dino_motion_ctrl;

    typedef struct {
        logic [1:0] st;
        logic       j;
        logic       t;
        logic [9:0] ox;
        logic       ov;
        logic [9:0] y;
        logic       a;
        logic       c;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       frame_tick = 1'b0;
    logic [1:0] state = 2'b00;
    logic       jump = 1'b0;
    logic [9:0] obs_x = '0;
    logic       obs_valid = 1'b0;
    logic [9:0] dino_y;
    logic       airborne;
    logic       collided;

    int errors = 0;
    int checks = 0;
    vec_t vecs[34];

    always #5 clk = ~clk;

    dino_motion_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .frame_tick_i (frame_tick),
        .state_i      (state),
        .jump_i       (jump),
        .obs_x_i      (obs_x),
        .obs_valid_i  (obs_valid),
        .dino_y_o     (dino_y),
        .airborne_o   (airborne),
        .collided_o   (collided)
    );

    function automatic vec_t mk(logic [1:0] st, logic j, logic t, int ox, logic ov,
                                int y, logic a, logic c);
        vec_t v;
        v.st = st; v.j = j; v.t = t; v.ox = 10'(ox); v.ov = ov;
        v.y = 10'(y); v.a = a; v.c = c;
        return v;
    endfunction

    // Hand-derived trajectory: 15 rising ticks, 6 more at the apex, 15 falling.
    function automatic int exp_y(int k);
        if (k <= 15) return 200 - 4 * k;
        if (k <= 21) return 140;
        return 140 + 4 * (k - 21);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic start_game();
        state = 2'b00; jump = 1'b0; obs_valid = 1'b0;
        step();
        state = 2'b10; jump = 1'b1;
        step();
        jump = 1'b0;
        chk("latched press no move", 32'(airborne), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(2'b00, 1, 1,  0, 0, 200, 0, 0);
        vecs[1]  = mk(2'b00, 1, 0,  0, 0, 200, 0, 0);
        vecs[2]  = mk(2'b00, 1, 1,  0, 0, 200, 0, 0);
        vecs[3]  = mk(2'b11, 1, 1,  0, 0, 200, 0, 0);
        vecs[4]  = mk(2'b10, 0, 0, 50, 1, 200, 0, 0);
        vecs[5]  = mk(2'b10, 0, 1, 50, 1, 200, 0, 0);
        vecs[6]  = mk(2'b10, 0, 0, 50, 1, 200, 0, 1);
        vecs[7]  = mk(2'b10, 0, 0, 50, 1, 200, 0, 0);
        vecs[8]  = mk(2'b10, 0, 1, 50, 1, 200, 0, 0);
        vecs[9]  = mk(2'b10, 0, 0, 50, 1, 200, 0, 0);
        vecs[10] = mk(2'b00, 0, 0, 50, 1, 200, 0, 0);
        vecs[11] = mk(2'b10, 0, 1, 50, 1, 200, 0, 0);
        vecs[12] = mk(2'b10, 0, 0, 50, 1, 200, 0, 1);
        vecs[13] = mk(2'b00, 0, 0, 60, 1, 200, 0, 0);
        vecs[14] = mk(2'b10, 0, 1, 60, 1, 200, 0, 0);
        vecs[15] = mk(2'b10, 0, 0, 60, 1, 200, 0, 0);
        vecs[16] = mk(2'b00, 0, 0, 28, 1, 200, 0, 0);
        vecs[17] = mk(2'b10, 0, 1, 28, 1, 200, 0, 0);
        vecs[18] = mk(2'b10, 0, 0, 28, 1, 200, 0, 0);
        vecs[19] = mk(2'b00, 0, 0, 29, 1, 200, 0, 0);
        vecs[20] = mk(2'b10, 0, 1, 29, 1, 200, 0, 0);
        vecs[21] = mk(2'b10, 0, 0, 29, 1, 200, 0, 1);
        vecs[22] = mk(2'b00, 0, 0, 59, 1, 200, 0, 0);
        vecs[23] = mk(2'b10, 0, 1, 59, 1, 200, 0, 0);
        vecs[24] = mk(2'b10, 0, 0, 59, 1, 200, 0, 1);
        vecs[25] = mk(2'b00, 0, 0,  0, 0, 200, 0, 0);
        vecs[26] = mk(2'b10, 0, 0,  0, 0, 200, 0, 0);
        vecs[27] = mk(2'b01, 1, 1,  0, 0, 200, 0, 0);
        vecs[28] = mk(2'b00, 0, 0,  0, 0, 200, 0, 0);
        vecs[29] = mk(2'b10, 1, 1,  0, 0, 196, 1, 0);
        vecs[30] = mk(2'b11, 0, 0,  0, 0, 200, 0, 0);
        vecs[31] = mk(2'b10, 0, 1, 50, 0, 200, 0, 0);
        vecs[32] = mk(2'b10, 0, 0, 50, 0, 200, 0, 0);
        vecs[33] = mk(2'b00, 0, 0,  0, 0, 200, 0, 0);

        #2 rst_n = 1'b0;
        #1;
        chk("reset dino_y", 32'(dino_y), 32'd200);
        chk("reset airborne", 32'(airborne), 32'd0);
        chk("reset collided", 32'(collided), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 34; i++) begin
            state = vecs[i].st; jump = vecs[i].j; frame_tick = vecs[i].t;
            obs_x = vecs[i].ox; obs_valid = vecs[i].ov;
            step();
            chk($sformatf("vec%0d dino_y", i), 32'(dino_y), 32'(vecs[i].y));
            chk($sformatf("vec%0d airborne", i), 32'(airborne), 32'(vecs[i].a));
            chk($sformatf("vec%0d collided", i), 32'(collided), 32'(vecs[i].c));
        end
        frame_tick = 1'b0; jump = 1'b0;

        start_game();
        for (int k = 1; k <= 36; k++) begin
            tick();
            chk($sformatf("traj%0d dino_y", k), 32'(dino_y), 32'(exp_y(k)));
            chk($sformatf("traj%0d airborne", k), 32'(airborne), (k < 36) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("traj%0d collided", k), 32'(collided), 32'd0);
        end

        start_game();
        for (int k = 1; k <= 15; k++) begin
            tick();
            step();
        end
        chk("apex dino_y", 32'(dino_y), 32'd140);
        obs_x = 10'd45; obs_valid = 1'b1;
        for (int k = 16; k <= 32; k++) begin
            tick();
            step();
            chk($sformatf("air col tick%0d", k), 32'(collided), (k == 31) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("air col tick%0d+1", k), 32'(collided), 32'd0);
        end

        start_game();
        for (int k = 1; k <= 5; k++) begin
            tick();
            step();
        end
        chk("mid rise dino_y", 32'(dino_y), 32'd180);
        state = 2'b01; jump = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            step();
            chk($sformatf("dead freeze%0d dino_y", k), 32'(dino_y), 32'd180);
            chk($sformatf("dead freeze%0d airborne", k), 32'(airborne), 32'd1);
        end
        jump = 1'b0; state = 2'b00;
        step();
        chk("init after dead dino_y", 32'(dino_y), 32'd200);
        chk("init after dead airborne", 32'(airborne), 32'd0);

        start_game();
        for (int k = 1; k <= 25; k++) begin
            tick();
            step();
        end
        chk("mid fall dino_y", 32'(dino_y), 32'd156);
        chk("mid fall airborne", 32'(airborne), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst dino_y", 32'(dino_y), 32'd200);
        chk("async rst airborne", 32'(airborne), 32'd0);
        chk("async rst collided", 32'(collided), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
